// File: rtl/pc_seq_if.sv
// Request/bus bundle between the control unit, the PC-source multiplexer and pc_seq.
// master: control/mux side. slave: the sequencer.
interface pc_seq_if;
  logic        req_seq;
  logic        req_branch;
  logic        branch_taken;
  logic        req_jump;
  logic        req_jr;
  logic        req_rte;
  logic        exc_req;
  logic [1:0]  exc_code;
  logic [31:0] mux_out;
  logic [2:0]  pc_src;
  logic        pc_write;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        vec_rd;
  logic [31:0] vec_addr;
  logic        busy;

  modport master (
    output req_seq, req_branch, branch_taken, req_jump, req_jr, req_rte,
    output exc_req, exc_code, mux_out,
    input  pc_src, pc_write, pc, epc, cause, vec_rd, vec_addr, busy
  );

  modport slave (
    input  req_seq, req_branch, branch_taken, req_jump, req_jr, req_rte,
    input  exc_req, exc_code, mux_out,
    output pc_src, pc_write, pc, epc, cause, vec_rd, vec_addr, busy
  );
endinterface

// File: rtl/pc_seq.sv
// PC sequencer: decodes PC requests into a PC-source select/write strobe, owns PC/EPC, runs exception entry.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] VEC_BASE = 32'h0000_00F0,
  parameter int          MEM_WAIT = 1
) (
  input  logic   clk,
  input  logic   reset,
  pc_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXC_RD, EXC_WAIT, EXC_LOAD} state_t;

  localparam logic [2:0] SRC_A    = 3'b000;
  localparam logic [2:0] SRC_ALUO = 3'b001;
  localparam logic [2:0] SRC_JMP  = 3'b010;
  localparam logic [2:0] SRC_EPC  = 3'b011;
  localparam logic [2:0] SRC_MDR  = 3'b100;
  localparam logic [2:0] SRC_ALU  = 3'b101;
  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] pc, epc;
  logic [1:0]  cause;
  logic [2:0]  pc_src;
  logic        pc_write;
  logic        vec_rd;
  logic [31:0] vec_addr;
  logic        exc_take;
  logic [31:0] epc_save;
  logic [1:0]  cause_save;
  logic        win;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pc    <= RESET_PC;
      epc   <= '0;
      cause <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pc_write) pc <= bus.mux_out;
      if (exc_take) begin
        epc   <= epc_save;
        cause <= cause_save;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    pc_src     = SRC_ALU;
    pc_write   = 1'b0;
    vec_rd     = 1'b0;
    vec_addr   = '0;
    exc_take   = 1'b0;
    epc_save   = pc - 32'd4;
    cause_save = bus.exc_code;
    win        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.exc_req) begin
          exc_take  = 1'b1;
          state_nxt = EXC_RD;
        end else begin
          win = 1'b1;
          if (bus.req_rte)                           pc_src = SRC_EPC;
          else if (bus.req_jr)                       pc_src = SRC_A;
          else if (bus.req_jump)                     pc_src = SRC_JMP;
          else if (bus.req_branch && bus.branch_taken) pc_src = SRC_ALUO;
          else if (bus.req_seq)                      pc_src = SRC_ALU;
          else                                       win = 1'b0;
          pc_write = win;
`ifdef PC_ALIGN_CHECK_EN
          // Misaligned target: keep the select visible but trap instead of writing.
          if (win && (bus.mux_out[1:0] != 2'b00)) begin
            pc_write   = 1'b0;
            exc_take   = 1'b1;
            epc_save   = pc;
            cause_save = 2'd3;
            state_nxt  = EXC_RD;
          end
`endif
        end
      end
      EXC_RD: begin
        vec_rd   = 1'b1;
        vec_addr = VEC_BASE + {28'd0, cause, 2'b00};
        if (WAIT_INIT == 4'd0) begin
          state_nxt = EXC_LOAD;
        end else begin
          state_nxt = EXC_WAIT;
          cnt_nxt   = WAIT_INIT;
        end
      end
      EXC_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = EXC_LOAD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      EXC_LOAD: begin
        pc_src    = SRC_MDR;
        pc_write  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pc_src   = pc_src;
  assign bus.pc_write = pc_write;
  assign bus.pc       = pc;
  assign bus.epc      = epc;
  assign bus.cause    = cause;
  assign bus.vec_rd   = vec_rd;
  assign bus.vec_addr = vec_addr;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: decode table, exception/reset sequences, randomized run vs cycle model.
module tb_pc_seq;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] VEC_BASE = 32'h0000_00F0;
  localparam int          MEM_WAIT = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_seq_if bus();
  pc_seq #(.RESET_PC(RESET_PC), .VEC_BASE(VEC_BASE), .MEM_WAIT(MEM_WAIT))
    u_dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int checks = 0;
  int errors = 0;

  // Model: age counts cycles since exception entry (0 = idle).
  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  int          m_age;

  typedef struct {
    logic seq, br, tk, jmp, jr, rte;
    logic [31:0] mux;
    logic [2:0]  src;
    logic        wr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic seq, br, tk, jmp, jr, rte, exc, input logic [1:0] code,
                       input logic [31:0] mux);
    bus.req_seq = seq; bus.req_branch = br; bus.branch_taken = tk; bus.req_jump = jmp;
    bus.req_jr = jr; bus.req_rte = rte; bus.exc_req = exc; bus.exc_code = code; bus.mux_out = mux;
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_epc = '0; m_cause = '0; m_age = 0;
  endtask

  // Compare combinational outputs to the model, clock once, then compare registers.
  task automatic tick();
    logic [2:0]  e_src;
    logic        e_wr, e_rd, go, has;
    logic [31:0] e_va, n_epc;
    logic [1:0]  n_cause;
    #1;
    e_src = 3'b101; e_wr = 1'b0; e_rd = 1'b0; e_va = '0; go = 1'b0; has = 1'b0;
    n_epc = m_epc; n_cause = m_cause;
    if (m_age == 0) begin
      if (bus.exc_req) begin
        go = 1'b1; n_epc = m_pc - 32'd4; n_cause = bus.exc_code;
      end else begin
        has = 1'b1;
        if (bus.req_rte)                              e_src = 3'b011;
        else if (bus.req_jr)                          e_src = 3'b000;
        else if (bus.req_jump)                        e_src = 3'b010;
        else if (bus.req_branch && bus.branch_taken)  e_src = 3'b001;
        else if (bus.req_seq)                         e_src = 3'b101;
        else                                          has = 1'b0;
        e_wr = has;
`ifdef PC_ALIGN_CHECK_EN
        if (has && bus.mux_out[1:0] != 2'b00) begin
          e_wr = 1'b0; go = 1'b1; n_epc = m_pc; n_cause = 2'd3;
        end
`endif
      end
    end else begin
      e_rd = (m_age == 1);
      e_va = e_rd ? VEC_BASE + 32'(4 * int'(m_cause)) : 32'd0;
      if (m_age == MEM_WAIT + 2) begin
        e_src = 3'b100; e_wr = 1'b1;
      end
    end
    chk("pc_src", 32'(bus.pc_src), 32'(e_src));
    chk("pc_write", 32'(bus.pc_write), 32'(e_wr));
    chk("vec_rd", 32'(bus.vec_rd), 32'(e_rd));
    chk("vec_addr", bus.vec_addr, e_va);
    chk("busy", 32'(bus.busy), 32'(m_age != 0));
    if (e_wr) m_pc = bus.mux_out;
    m_epc = n_epc; m_cause = n_cause;
    if (m_age == 0) m_age = go ? 1 : 0;
    else            m_age = (m_age == MEM_WAIT + 2) ? 0 : m_age + 1;
    @(posedge clk); #1;
    chk("pc", bus.pc, m_pc);
    chk("epc", bus.epc, m_epc);
    chk("cause", 32'(bus.cause), 32'(m_cause));
    chk("busy_after", 32'(bus.busy), 32'(m_age != 0));
  endtask

  vec_t tbl [9];

  initial begin
    tbl[0] = '{1,0,0,0,0,0, 32'h104, 3'b101, 1'b1};
    tbl[1] = '{0,1,0,0,0,0, 32'h200, 3'b101, 1'b0};
    tbl[2] = '{0,1,1,0,0,0, 32'h040, 3'b001, 1'b1};
    tbl[3] = '{1,0,0,1,1,0, 32'h200, 3'b000, 1'b1};
    tbl[4] = '{0,1,1,1,0,0, 32'h300, 3'b010, 1'b1};
    tbl[5] = '{0,0,0,0,1,1, 32'h000, 3'b011, 1'b1};
    tbl[6] = '{1,1,1,0,0,0, 32'h044, 3'b001, 1'b1};
    tbl[7] = '{0,0,0,0,0,0, 32'h500, 3'b101, 1'b0};
    tbl[8] = '{1,1,0,0,0,0, 32'h048, 3'b101, 1'b1};

    drive(0,0,0,0,0,0,0,2'd0,32'h0);
    model_reset();
    #2;
    chk("rst_pc", bus.pc, RESET_PC);
    chk("rst_epc", bus.epc, 32'h0);
    chk("rst_cause", 32'(bus.cause), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_pc_write", 32'(bus.pc_write), 32'h0);
    chk("rst_vec_rd", 32'(bus.vec_rd), 32'h0);
    chk("rst_pc_src", 32'(bus.pc_src), 32'h5);
    chk("rst_vec_addr", bus.vec_addr, 32'h0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // Sequential fetch: pc 4, 8, C.
    for (int i = 1; i <= 3; i++) begin
      drive(1,0,0,0,0,0,0,2'd0, bus.pc + 32'd4);
      tick();
      chk("seq_pc", bus.pc, 32'(4 * i));
    end

    // Decode table.
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].seq, tbl[i].br, tbl[i].tk, tbl[i].jmp, tbl[i].jr, tbl[i].rte, 0, 2'd0, tbl[i].mux);
      #1;
      chk("tbl_src", 32'(bus.pc_src), 32'(tbl[i].src));
      chk("tbl_wr", 32'(bus.pc_write), 32'(tbl[i].wr));
      tick();
    end

    // Exception entry from pc=0x20, cause 1; req_seq during busy is ignored.
    drive(0,0,0,1,0,0,0,2'd0,32'h20); tick();
    drive(0,0,0,0,0,0,1,2'd1,32'h20); tick();
    chk("exc_epc", bus.epc, 32'h1C);
    chk("exc_cause", 32'(bus.cause), 32'd1);
    drive(1,0,0,0,0,0,0,2'd0,32'h24);
    #1;
    chk("exc_vec_rd", 32'(bus.vec_rd), 32'd1);
    chk("exc_vec_addr", bus.vec_addr, 32'hF4);
    tick();
    #1;
    chk("exc_vec_rd_once", 32'(bus.vec_rd), 32'd0);
    tick();
    drive(1,0,0,0,0,0,0,2'd0,32'h800);
    #1;
    chk("exc_load_src", 32'(bus.pc_src), 32'h4);
    tick();
    chk("exc_load_pc", bus.pc, 32'h800);
    chk("exc_busy_fall", 32'(bus.busy), 32'd0);
    drive(1,0,0,0,0,0,0,2'd0,32'h804); tick();
    chk("b2b_pc", bus.pc, 32'h804);

    // Exception at pc=0x104 gives epc=0x100; exception beats a simultaneous rte.
    drive(0,0,0,1,0,0,0,2'd0,32'h104); tick();
    drive(0,0,0,0,0,1,1,2'd0,32'h104); tick();
    chk("exc_vs_rte_epc", bus.epc, 32'h100);
    for (int i = 0; i < MEM_WAIT + 2; i++) begin
      drive(0,0,0,0,0,0,0,2'd0,32'h900); tick();
    end
    drive(0,0,0,0,0,1,0,2'd0,32'h100);
    #1;
    chk("rte_src", 32'(bus.pc_src), 32'h3);
    tick();
    chk("rte_pc", bus.pc, 32'h100);

    // Reset asserted during EXC_WAIT aborts the sequence.
    drive(0,0,0,0,0,0,1,2'd2,32'h0); tick();
    drive(0,0,0,0,0,0,0,2'd0,32'h0); tick();
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_pc", bus.pc, RESET_PC);
    chk("mid_rst_epc", bus.epc, 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    #2 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_vec_rd", 32'(bus.vec_rd), 32'd0);
    end

    // Misaligned jump target.
    drive(0,0,0,1,0,0,0,2'd0,32'h30); tick();
    drive(0,0,0,1,0,0,0,2'd0,32'h42); tick();
`ifdef PC_ALIGN_CHECK_EN
    chk("align_pc_hold", bus.pc, 32'h30);
    chk("align_epc", bus.epc, 32'h30);
    chk("align_cause", 32'(bus.cause), 32'd3);
    drive(0,0,0,0,0,0,0,2'd0,32'h80);
    #1;
    chk("align_vec_addr", bus.vec_addr, 32'hFC);
    for (int i = 0; i < MEM_WAIT + 2; i++) tick();
    chk("align_load_pc", bus.pc, 32'h80);
`else
    chk("noalign_pc", bus.pc, 32'h42);
`endif

    // Randomized run against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] mx;
      mx = $urandom;
      if ($urandom_range(3) != 0) mx[1:0] = 2'b00;
      drive($urandom_range(1), $urandom_range(3) == 0, $urandom_range(1),
            $urandom_range(5) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0,
            $urandom_range(9) == 0, 2'($urandom_range(3)), mx);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
